// File: rtl/led_shift_ctrl_if.sv
// Signal bundle between the LED shift controller and its surroundings:
// raw buttons and shifter done flag in, shifter controls and status out.
interface led_shift_ctrl_if #(
   parameter int ROUND_W = 8
);
   logic               btn_run;
   logic               btn_dir;
   logic               done_in;
   logic               direction;
   logic               step_en;
   logic               restart;
   logic               running;
   logic [ROUND_W-1:0] round_cnt;

   modport master (
      output btn_run, btn_dir, done_in,
      input  direction, step_en, restart, running, round_cnt
   );

   modport slave (
      input  btn_run, btn_dir, done_in,
      output direction, step_en, restart, running, round_cnt
   );
endinterface

// File: rtl/led_shift_ctrl.sv
// LED shifter control: button debounce, direction toggle, step prescaler and round FSM.
// Optional build macro AUTO_RESTART_EN: re-enter RUN automatically after RESTART.

// One button lane: 2-flop synchroniser, debounce counter, press strobe.
module led_btn_db #(
   parameter int DB_CNT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;
   logic          flip;

   // Accepted level flips on the DB_CNT-th consecutive differing sample.
   assign flip = (sync[1] != level) && (cnt == CW'(DB_CNT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         press <= flip && sync[1];
         if (flip) begin
            level <= sync[1];
            cnt   <= '0;
         end else if (sync[1] != level) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

module led_shift_ctrl #(
   parameter int DB_CNT   = 1_000_000,
   parameter int STEP_DIV = 25_000_000,
   parameter int ROUND_W  = 8
) (
   input logic         clk,
   input logic         reset,
   led_shift_ctrl_if.slave bus
);
   localparam int NUM_BTN = 2;
   localparam int PW      = $clog2(STEP_DIV);

   typedef enum logic [1:0] {IDLE, RUN, DONE, RESTART} state_t;

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] press;
   logic               run_press;
   logic               dir_press;

   state_t             state, state_n;
   logic [PW-1:0]      pcnt;
   logic               at_top;
   logic               stay_run;
   logic               dir_q;
   logic [ROUND_W-1:0] rnd_q;

   assign raw = {bus.btn_dir, bus.btn_run};

   led_btn_db #(.DB_CNT(DB_CNT)) u_db [NUM_BTN-1:0] (
      .clk   (clk),
      .reset (reset),
      .raw   (raw),
      .press (press)
   );

   assign run_press = press[0];
   assign dir_press = press[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (run_press) state_n = RUN;
         RUN: begin
            // done wins over a simultaneous pause press, which is dropped
            if (bus.done_in)    state_n = DONE;
            else if (run_press) state_n = IDLE;
         end
         DONE:    state_n = RESTART;
`ifdef AUTO_RESTART_EN
         RESTART: state_n = RUN;
`else
         RESTART: state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
   end

   assign stay_run = (state == RUN) && (state_n == RUN);
   assign at_top   = (pcnt == PW'(STEP_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt  <= '0;
         dir_q <= 1'b1;
         rnd_q <= '0;
      end else begin
         pcnt <= (stay_run && !at_top) ? pcnt + 1'b1 : '0;
         if (dir_press) dir_q <= ~dir_q;
         if (state == DONE && rnd_q != '1) rnd_q <= rnd_q + 1'b1;
      end
   end

   // Strobe is suppressed on the final RUN cycle so no step leaks into an exit.
   assign bus.step_en   = stay_run && at_top;
   assign bus.running   = (state == RUN);
   assign bus.restart   = (state == RESTART);
   assign bus.direction = dir_q;
   assign bus.round_cnt = rnd_q;
endmodule
